// File: rtl/cpu_pkg.sv
// Shared definitions for the 32-bit core pipeline.
// Contents:
//   XLEN, NUM_REGS, AW, OPW  - datapath width, register count, index width, opcode width
//   reg_idx_t                - architectural register index
//   op_t                     - opaque opcode carried to execute
//   issue_bundle_t           - operand bundle presented on the execute interface
//   wb_hits()                - true when a writeback targets a given (non-zero) register
package cpu_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 8;
  localparam int AW       = 3;
  localparam int OPW      = 4;

  typedef logic [AW-1:0]  reg_idx_t;
  typedef logic [OPW-1:0] op_t;

  typedef struct packed {
    op_t             op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
    reg_idx_t        rd;
    logic            rd_we;
  } issue_bundle_t;

  // Register 0 is hardwired to zero, so a writeback to it never counts as a hit.
  function automatic logic wb_hits(input logic wb_valid, input reg_idx_t wb_rd,
                                   input reg_idx_t r);
    return wb_valid && (wb_rd == r) && (r != '0);
  endfunction

endpackage

// File: rtl/operand_scoreboard.sv
// Per-register outstanding-write scoreboard.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   wb_valid, wb_rd      - writeback this cycle; clears the busy bit of wb_rd
//   set_en, set_rd       - an accepted instruction will write set_rd
//   flush_clr, flush_rd  - a flushed instruction no longer owns flush_rd
//   rs1, rs2, rd         - lookup indices
//   eff_rs1/eff_rs2/eff_rd - busy and not being written back this cycle
//   busy                 - raw scoreboard state
module operand_scoreboard
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_valid,
  input  logic [AW-1:0]       wb_rd,
  input  logic                set_en,
  input  logic [AW-1:0]       set_rd,
  input  logic                flush_clr,
  input  logic [AW-1:0]       flush_rd,
  input  logic [AW-1:0]       rs1,
  input  logic [AW-1:0]       rs2,
  input  logic [AW-1:0]       rd,
  output logic                eff_rs1,
  output logic                eff_rs2,
  output logic                eff_rd,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] busy_next;

  // Clears are applied before the set so a register retired and re-claimed
  // in the same cycle stays busy for its new owner.
  always_comb begin
    busy_next = busy;
    if (wb_hits(wb_valid, wb_rd, wb_rd)) busy_next[wb_rd] = 1'b0;
    if (flush_clr) busy_next[flush_rd] = 1'b0;
    if (set_en && (set_rd != '0)) busy_next[set_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

  // A register being written back this cycle is already resolved via bypass.
  assign eff_rs1 = busy[rs1] & ~wb_hits(wb_valid, wb_rd, rs1);
  assign eff_rs2 = busy[rs2] & ~wb_hits(wb_valid, wb_rd, rs2);
  assign eff_rd  = busy[rd]  & ~wb_hits(wb_valid, wb_rd, rd);

endmodule

// File: rtl/operand_fetch.sv
// Issue / operand-fetch stage between decode and execute.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   flush                       - kill the instruction held in the output register
//   id_*                        - decoded instruction and its valid/ready handshake
//   rf_read_addr_*/rf_read_data_* - asynchronous register file read ports
//   wb_valid, wb_rd, wb_data    - writeback (also the register file write)
//   ex_*                        - registered operand bundle with valid/ready handshake
//   busy                        - scoreboard state
module operand_fetch
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic [OPW-1:0]      id_op,
  input  logic [AW-1:0]       id_rs1,
  input  logic [AW-1:0]       id_rs2,
  input  logic                id_use_rs2,
  input  logic [AW-1:0]       id_rd,
  input  logic                id_rd_we,
  input  logic [XLEN-1:0]     id_imm,
  output logic [AW-1:0]       rf_read_addr_1,
  input  logic [XLEN-1:0]     rf_read_data_1,
  output logic [AW-1:0]       rf_read_addr_2,
  input  logic [XLEN-1:0]     rf_read_data_2,
  input  logic                wb_valid,
  input  logic [AW-1:0]       wb_rd,
  input  logic [XLEN-1:0]     wb_data,
  output logic                ex_valid,
  input  logic                ex_ready,
  output logic [OPW-1:0]      ex_op,
  output logic [XLEN-1:0]     ex_a,
  output logic [XLEN-1:0]     ex_b,
  output logic [XLEN-1:0]     ex_imm,
  output logic [AW-1:0]       ex_rd,
  output logic                ex_rd_we,
  output logic [NUM_REGS-1:0] busy
);

  issue_bundle_t   ex_reg;
  issue_bundle_t   issue_next;
  logic            eff_rs1, eff_rs2, eff_rd;
  logic            hazard;
  logic            accept;
  logic [XLEN-1:0] opnd_1, opnd_2;

  assign rf_read_addr_1 = id_rs1;
  assign rf_read_addr_2 = id_rs2;

  operand_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .set_en    (accept & id_rd_we),
    .set_rd    (id_rd),
    .flush_clr (flush & ex_valid & ex_reg.rd_we),
    .flush_rd  (ex_reg.rd),
    .rs1       (id_rs1),
    .rs2       (id_rs2),
    .rd        (id_rd),
    .eff_rs1   (eff_rs1),
    .eff_rs2   (eff_rs2),
    .eff_rd    (eff_rd),
    .busy      (busy)
  );

  // Register file writes only land at the next edge, so a same-cycle
  // writeback has to be forwarded here.
  always_comb begin
    opnd_1 = rf_read_data_1;
    opnd_2 = rf_read_data_2;
    if (id_rs1 == '0)                          opnd_1 = '0;
    else if (wb_hits(wb_valid, wb_rd, id_rs1)) opnd_1 = wb_data;
    if (id_rs2 == '0)                          opnd_2 = '0;
    else if (wb_hits(wb_valid, wb_rd, id_rs2)) opnd_2 = wb_data;
  end

  assign hazard   = eff_rs1 | (id_use_rs2 & eff_rs2) | (id_rd_we & eff_rd);
  assign id_ready = ~flush & ~hazard & (~ex_valid | ex_ready);
  assign accept   = id_valid & id_ready;

  always_comb begin
    issue_next.op    = id_op;
    issue_next.a     = opnd_1;
    issue_next.b     = id_use_rs2 ? opnd_2 : '0;
    issue_next.imm   = id_imm;
    issue_next.rd    = id_rd;
    issue_next.rd_we = id_rd_we;
  end

  // Output register: bundle fields only change on accept, so they hold
  // steady while execute back-pressures.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_reg   <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (accept) begin
      ex_valid <= 1'b1;
      ex_reg   <= issue_next;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  assign ex_op    = ex_reg.op;
  assign ex_a     = ex_reg.a;
  assign ex_b     = ex_reg.b;
  assign ex_imm   = ex_reg.imm;
  assign ex_rd    = ex_reg.rd;
  assign ex_rd_we = ex_reg.rd_we;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios followed by
// random traffic, compared against a behavioural model of the stage.
module tb_operand_fetch;
  import cpu_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            id_valid = 1'b0;
  logic            id_ready;
  logic [OPW-1:0]  id_op = '0;
  logic [AW-1:0]   id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic            id_use_rs2 = 1'b0, id_rd_we = 1'b0;
  logic [XLEN-1:0] id_imm = '0;
  logic [AW-1:0]   rf_read_addr_1, rf_read_addr_2;
  logic [XLEN-1:0] rf_read_data_1, rf_read_data_2;
  logic            wb_valid = 1'b0;
  logic [AW-1:0]   wb_rd = '0;
  logic [XLEN-1:0] wb_data = '0;
  logic            ex_valid;
  logic            ex_ready = 1'b0;
  logic [OPW-1:0]  ex_op;
  logic [XLEN-1:0] ex_a, ex_b, ex_imm;
  logic [AW-1:0]   ex_rd;
  logic            ex_rd_we;
  logic [NUM_REGS-1:0] busy;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready), .id_op(id_op),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_imm(id_imm),
    .rf_read_addr_1(rf_read_addr_1), .rf_read_data_1(rf_read_data_1),
    .rf_read_addr_2(rf_read_addr_2), .rf_read_data_2(rf_read_data_2),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
    .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .busy(busy)
  );

  // Register file the stage reads from; entry 0 holds garbage on purpose.
  logic [XLEN-1:0] rf [NUM_REGS];
  assign rf_read_data_1 = rf[rf_read_addr_1];
  assign rf_read_data_2 = rf[rf_read_addr_2];

  always @(posedge clk) begin
    if (wb_valid && wb_rd != '0) rf[wb_rd] <= wb_data;
  end

  // Reference model state
  bit            busy_m [NUM_REGS];
  issue_bundle_t exp_q [$];
  int            inflight [$];
  int            checks = 0;
  int            failures = 0;
  bit            mon_en = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic bit effBusy(input int r, input bit wbv, input int wbr);
    return busy_m[r] && !(wbv && wbr == r && r != 0);
  endfunction

  function automatic logic [XLEN-1:0] srcVal(input int s, input bit wbv, input int wbr,
                                             input logic [XLEN-1:0] wbd);
    if (s == 0) return '0;
    if (wbv && wbr == s) return wbd;
    return rf[s];
  endfunction

  function automatic void dropInflight(input int r);
    for (int i = 0; i < inflight.size(); i++) begin
      if (inflight[i] == r) begin
        inflight.delete(i);
        return;
      end
    end
  endfunction

  function automatic logic [NUM_REGS-1:0] busyVec();
    logic [NUM_REGS-1:0] v = '0;
    for (int i = 0; i < NUM_REGS; i++) v[i] = busy_m[i];
    return v;
  endfunction

  // One cycle: drive at negedge, check combinational outputs, then commit
  // the model's view of the upcoming edge after the monitor has sampled.
  task automatic applyStimulus(input bit v, input int rs1, input int rs2, input bit use2,
                               input int rd, input bit we, input bit exr, input bit fl,
                               input bit wbv, input int wbr, input logic [XLEN-1:0] wbd);
    bit            held, ready_m, acc, consumed, fl_clr;
    int            fl_rd;
    issue_bundle_t nb;
    @(negedge clk);
    id_valid = v; id_rs1 = rs1[AW-1:0]; id_rs2 = rs2[AW-1:0]; id_use_rs2 = use2;
    id_rd = rd[AW-1:0]; id_rd_we = we; id_op = OPW'($urandom); id_imm = $urandom;
    ex_ready = exr; flush = fl;
    wb_valid = wbv; wb_rd = wbr[AW-1:0]; wb_data = wbd;
    #1;
    held    = exp_q.size() > 0;
    ready_m = !fl && !effBusy(rs1, wbv, wbr) && !(use2 && effBusy(rs2, wbv, wbr))
              && !(we && effBusy(rd, wbv, wbr)) && (!held || exr);
    checkOutput("id_ready", id_ready, ready_m);
    checkOutput("busy", busy, busyVec());
    checkOutput("rf_addr1", rf_read_addr_1, rs1);
    acc = v && ready_m;
    nb.op    = id_op;
    nb.a     = srcVal(rs1, wbv, wbr, wbd);
    nb.b     = use2 ? srcVal(rs2, wbv, wbr, wbd) : '0;
    nb.imm   = id_imm;
    nb.rd    = id_rd;
    nb.rd_we = we;
    consumed = held && exr && !fl && exp_q[0].rd_we && exp_q[0].rd != 0;
    fl_clr   = held && fl && exp_q[0].rd_we;
    fl_rd    = held ? int'(exp_q[0].rd) : 0;
    #2;
    if (wbv && wbr != 0) busy_m[wbr] = 1'b0;
    if (fl_clr) busy_m[fl_rd] = 1'b0;
    if (acc && we && rd != 0) busy_m[rd] = 1'b1;
    if (consumed) inflight.push_back(fl_rd);
    if (acc) exp_q.push_back(nb);
  endtask

  task automatic resetDut();
    @(negedge clk);
    mon_en = 1'b0;
    rst = 1'b1;
    id_valid = 1'b1; id_rd = 3'd2; id_rd_we = 1'b1; ex_ready = 1'b0;
    wb_valid = 1'b1; wb_rd = 3'd7; wb_data = 32'h7777_0007; flush = 1'b1;
    @(negedge clk);
    rst = 1'b0; id_valid = 1'b0; wb_valid = 1'b0; flush = 1'b0;
    exp_q.delete();
    inflight.delete();
    for (int i = 0; i < NUM_REGS; i++) busy_m[i] = 1'b0;
    #1;
    checkOutput("rst_ex_valid", ex_valid, 0);
    checkOutput("rst_ex_op", ex_op, 0);
    checkOutput("rst_ex_a", ex_a, 0);
    checkOutput("rst_ex_b", ex_b, 0);
    checkOutput("rst_ex_imm", ex_imm, 0);
    checkOutput("rst_ex_rd", ex_rd, 0);
    checkOutput("rst_ex_rd_we", ex_rd_we, 0);
    checkOutput("rst_busy", busy, 0);
    mon_en = 1'b1;
  endtask

  // Monitor: compares the presented bundle against the expected queue and
  // retires it when execute takes it or it is flushed.
  initial begin
    issue_bundle_t e;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        checkOutput("ex_valid", ex_valid, exp_q.size() != 0);
        if (exp_q.size() > 0) begin
          e = exp_q[0];
          checkOutput("ex_op", ex_op, e.op);
          checkOutput("ex_a", ex_a, e.a);
          checkOutput("ex_b", ex_b, e.b);
          checkOutput("ex_imm", ex_imm, e.imm);
          checkOutput("ex_rd", ex_rd, e.rd);
          checkOutput("ex_rd_we", ex_rd_we, e.rd_we);
          if (ex_ready || flush) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    bit wbv;
    int wbr, k, n;
    for (int i = 0; i < NUM_REGS; i++) rf[i] = 32'h100 * i;
    rf[0] = 32'hFFFF_FFFF;
    rf[2] = 32'h11;
    rf[3] = 32'h22;
    resetDut();

    // Basic read of r2/r3
    applyStimulus(1, 2, 3, 1, 1, 0, 1, 0, 0, 0, 0);
    // Claim r4, then a reader of r4 stalls until the writeback bypass
    applyStimulus(1, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0);
    applyStimulus(1, 4, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    applyStimulus(1, 4, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    dropInflight(4);
    applyStimulus(1, 4, 0, 0, 1, 0, 1, 0, 1, 4, 32'hDEAD);
    // r0 reads zero despite garbage in the file; rd=0 never becomes busy
    applyStimulus(1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0);
    // Claim r5 and hold it under back-pressure, then flush it
    applyStimulus(1, 2, 0, 0, 5, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0, 2, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 2, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 5, 0, 0, 7, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 3, 2, 1, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 3, 2, 1, 1, 0, 1, 0, 0, 0, 0);
    // Retire r6 and re-claim it in the same cycle
    applyStimulus(1, 0, 0, 0, 6, 1, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    dropInflight(6);
    applyStimulus(1, 0, 0, 0, 6, 1, 1, 0, 1, 6, 32'h6666);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

    // Random traffic with a mid-run reset
    for (int c = 0; c < 1200; c++) begin
      if (c == 600) resetDut();
      wbv = 0; wbr = 0;
      if (inflight.size() > 0 && $urandom_range(2) == 0) begin
        k = $urandom_range(inflight.size() - 1);
        wbr = inflight[k];
        inflight.delete(k);
        wbv = 1;
      end else if ($urandom_range(7) == 0) begin
        n = $urandom_range(NUM_REGS - 1);
        if (!busy_m[n]) begin wbv = 1; wbr = n; end
      end
      applyStimulus($urandom_range(9) < 8, $urandom_range(7), $urandom_range(7),
                    $urandom_range(1), $urandom_range(7), $urandom_range(1),
                    $urandom_range(9) < 7, $urandom_range(11) == 0,
                    wbv, wbr, $urandom);
    end

    // Drain: every claimed register must eventually be released
    n = 0;
    while ((exp_q.size() > 0 || inflight.size() > 0) && n < 300) begin
      wbv = 0; wbr = 0;
      if (inflight.size() > 0) begin
        wbr = inflight.pop_front();
        wbv = 1;
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, wbv, wbr, $urandom);
      n++;
    end
    checkOutput("drain_done", (exp_q.size() == 0 && inflight.size() == 0), 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    checkOutput("drain_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
